// File: rtl/rand_pack_fifo.sv
// Packs RANDNUM random words into bundles and queues up to DEPTH complete bundles
// for a downstream consumer. Define RAND_UNDERFLOW_FLAG_EN to enable the sticky underflow flag.
module rand_pack_fifo #(
    parameter int K_WIDTH = 32,
    parameter int RANDNUM = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [K_WIDTH-1:0]           i_rnd,
    input  logic                         i_rnd_vld,
    output logic                         o_rnd_rdy,
    input  logic                         i_take,
    output logic [K_WIDTH*RANDNUM-1:0]   o_n,
    output logic                         o_rvld,
    output logic [$clog2(DEPTH):0]       o_level,
    output logic                         o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = (RANDNUM > 1) ? $clog2(RANDNUM) : 1;
    localparam int BW = K_WIDTH * RANDNUM;

    logic [BW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          push, last_word, pop;

    assign o_rnd_rdy = (level_q != LW'(DEPTH));
    assign o_rvld    = (level_q != '0);
    assign o_level   = level_q;
    // Head is masked when empty so stale randomness never leaks downstream.
    assign o_n       = o_rvld ? mem_q[rd_ptr_q] : '0;

    assign push      = i_rnd_vld && o_rnd_rdy;
    assign last_word = push && (idx_q == IW'(RANDNUM - 1));
    assign pop       = i_take && o_rvld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        level_d  = level_q;
        if (push) begin
            if (last_word) begin
                idx_d    = '0;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                idx_d    = idx_q + IW'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (last_word && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !last_word) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
        end
    end

    // The write slot is never a complete bundle, so partial words stay hidden.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q][idx_q*K_WIDTH +: K_WIDTH] <= i_rnd;
        end
    end

`ifdef RAND_UNDERFLOW_FLAG_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (i_take && !o_rvld) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rand_pack_fifo.sv
// Scoreboard bench for rand_pack_fifo: the driver queues expected bundles, and a
// negedge monitor pops and compares each time a bundle is taken.
module tb_rand_pack_fifo;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] i_rnd = '0;
    logic        i_rnd_vld = 1'b0;
    logic        o_rnd_rdy;
    logic        i_take = 1'b0;
    logic [63:0] o_n;
    logic        o_rvld;
    logic [2:0]  o_level;
    logic        o_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] part_w = '0;
    int          part_n = 0;
    bit          done = 1'b0;
    logic        exp_err;

    rand_pack_fifo #(.K_WIDTH(32), .RANDNUM(2), .DEPTH(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_rnd    (i_rnd),
        .i_rnd_vld(i_rnd_vld),
        .o_rnd_rdy(o_rnd_rdy),
        .i_take   (i_take),
        .o_n      (o_n),
        .o_rvld   (o_rvld),
        .o_level  (o_level),
        .o_err    (o_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic record_word(input logic [31:0] w);
        if (part_n == 0) begin
            part_w = w;
            part_n = 1;
        end else begin
            exp_q.push_back({w, part_w});
            part_n = 0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        i_rnd     = w;
        i_rnd_vld = 1'b1;
        while (!o_rnd_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!o_rnd_rdy) check("push_timeout", 64'd0, 64'd1);
        tick();
        i_rnd_vld = 1'b0;
        $display("push %h", w);
        record_word(w);
    endtask

    task automatic take_one();
        i_take = 1'b1;
        tick();
        i_take = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (o_rvld && n < 20) begin
            take_one();
            n++;
        end
        check("drain_level", 64'(o_level), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   64'(o_rnd_rdy), 64'd1);
        check({tag, "_rvld"},  64'(o_rvld),    64'd0);
        check({tag, "_n"},     o_n,            64'd0);
        check({tag, "_level"}, 64'(o_level),   64'd0);
        check({tag, "_err"},   64'(o_err),     64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        part_n = 0;
    endtask

    // Monitor: a take seen at negedge is consumed at the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && i_take) begin
            if (o_rvld) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", o_n, 64'd0);
                    if (o_n == 64'd0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected: got %h expected no bundle", o_n);
                    end
                end else begin
                    $display("take %h", o_n);
                    check("sb_bundle", o_n, exp_q.pop_front());
                end
            end else begin
                check("underflow_n", o_n, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RAND_UNDERFLOW_FLAG_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        #1 rst_i = 1'b1;
        #2;
        check_reset_outputs("reset");
        release_reset();

        // Single bundle after reset
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        check("first_rvld",  64'(o_rvld),  64'd1);
        check("first_n",     o_n,          64'h2222_2222_1111_1111);
        check("first_level", 64'(o_level), 64'd1);
        drain();

        // Full and backpressure
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        check("full_level", 64'(o_level),   64'd4);
        check("full_rdy",   64'(o_rnd_rdy), 64'd0);
        i_rnd     = 32'h999;
        i_rnd_vld = 1'b1;
        tick(); tick(); tick();
        check("full_hold_level", 64'(o_level), 64'd4);
        i_take = 1'b1;
        tick();
        i_take = 1'b0;
        check("after_take_rdy",   64'(o_rnd_rdy), 64'd1);
        check("after_take_level", 64'(o_level),   64'd3);
        tick();
        i_rnd_vld = 1'b0;
        record_word(32'h999);
        check("ninth_level", 64'(o_level), 64'd3);
        push_word(32'h99A);
        check("refill_level", 64'(o_level), 64'd4);
        drain();

        // Bundle completes in the same cycle as a take
        for (int i = 0; i < 5; i++) push_word(32'h300 + 32'(i));
        check("simul_pre_level", 64'(o_level), 64'd2);
        i_rnd     = 32'h305;
        i_rnd_vld = 1'b1;
        i_take    = 1'b1;
        tick();
        i_rnd_vld = 1'b0;
        i_take    = 1'b0;
        record_word(32'h305);
        check("simul_level", 64'(o_level), 64'd2);
        check("simul_head",  o_n,          64'h0000_0303_0000_0302);
        drain();
        check("pre_underflow_err", 64'(o_err), 64'd0);

        // Underflow
        take_one();
        check("uf_level", 64'(o_level), 64'd0);
        check("uf_rvld",  64'(o_rvld),  64'd0);
        check("uf_err",   64'(o_err),   64'(exp_err));
        tick();
        check("uf_err_sticky", 64'(o_err), 64'(exp_err));
        push_word(32'h0000_0500);
        push_word(32'h0000_0501);
        check("uf_after_n", o_n, 64'h0000_0501_0000_0500);
        drain();

        // Reset mid-fill
        push_word(32'hAAAA_AAAA);
        rst_i = 1'b1;
        #2;
        check_reset_outputs("midfill");
        release_reset();
        push_word(32'h1);
        push_word(32'h2);
        check("midfill_n", o_n, 64'h0000_0002_0000_0001);
        drain();

        // Streaming with random takes across several pointer wraps
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) push_word(32'hC000_0000 + 32'(i));
                done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!(done && !o_rvld) && n < 2000) begin
                    i_take = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
                i_take = 1'b0;
            end
        join
        check("stream_level",    64'(o_level),     64'd0);
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rand_pack_fifo.md
RAND_PACK_FIFO -- requirements
Module: rand_pack_fifo

Interface
REQ-001 SHALL have parameter K_WIDTH, default 32: bit width of one random word and of one share.
REQ-002 SHALL have parameter RANDNUM, default 2: number of random words per bundle delivered to the downstream full-XOR stage.
REQ-003 SHALL have parameter DEPTH, default 4: bundle capacity; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_rnd, input, K_WIDTH: random word from the PRNG/TRNG.
REQ-007 SHALL have port i_rnd_vld, input, 1: i_rnd is valid.
REQ-008 SHALL have port o_rnd_rdy, output, 1: word accepted this cycle if i_rnd_vld is high.
REQ-009 SHALL have port i_take, input, 1: downstream consumes the head bundle this cycle; this is the downstream register-enable strobe.
REQ-010 SHALL have port o_n, output, K_WIDTH*RANDNUM: head bundle.
REQ-011 SHALL have port o_rvld, output, 1: o_n holds a complete, unconsumed bundle.
REQ-012 SHALL have port o_level, output, $clog2(DEPTH)+1: number of complete bundles stored.
REQ-013 SHALL have port o_err, output, 1: sticky underflow flag (see Configuration).

Function
REQ-014 SHALL store bundles in a DEPTH-entry register array with write pointer, read pointer, level counter and word index 0..RANDNUM-1.
REQ-015 SHALL drive o_rnd_rdy = (o_level != DEPTH), a function of registered state only.
REQ-016 SHALL, on i_rnd_vld && o_rnd_rdy, write i_rnd into slice [idx*K_WIDTH +: K_WIDTH] of the slot at the write pointer and increment idx.
REQ-017 SHALL, when idx = RANDNUM-1 is written, set idx to 0, advance the write pointer modulo DEPTH and increment o_level; the bundle is visible on o_n/o_rvld on the next cycle when it becomes the head.
REQ-018 SHALL drive o_rvld = (o_level != 0) and o_n = head slot when o_rvld is high, and all-zero otherwise, so stale randomness is never presented.
REQ-019 SHALL, on i_take && o_rvld, advance the read pointer modulo DEPTH and decrement o_level.
REQ-020 SHALL leave o_level unchanged when a bundle completes and a take occurs in the same cycle, and SHALL preserve FIFO order.
REQ-021 SHALL ignore i_take while o_rvld is low: no pointer or level change.
REQ-022 SHALL never expose a partial bundle; partial words stay invisible until the last word of the bundle is written.
REQ-023 SHALL wrap both pointers from DEPTH-1 to 0 without loss or duplication.

Reset
REQ-024 SHALL, while rst_i is high, immediately clear all pointers, idx, o_level, storage and o_err, giving o_rnd_rdy=1, o_rvld=0, o_n=0, o_level=0 and o_err=0.
REQ-025 SHALL discard any partial bundle on reset mid-fill; the first word after release fills slice 0.

Configuration
REQ-026 SHALL, with macro RAND_UNDERFLOW_FLAG_EN defined, set o_err on any cycle with i_take high and o_rvld low, and hold it until reset.
REQ-027 SHALL, without RAND_UNDERFLOW_FLAG_EN, tie o_err to 0 with no flag register; all other behaviour is identical.

Verification
(All scenarios use K_WIDTH=32, RANDNUM=2, DEPTH=4.)
REQ-028 Push after reset: words 0x11111111 then 0x22222222 -> next cycle o_rvld=1, o_n=0x2222222211111111, o_level=1.
REQ-029 Full and backpressure: push 8 words -> o_level=4, o_rnd_rdy=0; a 9th word held valid is not accepted. One take -> o_rnd_rdy=1 next cycle, and the 9th word is accepted.
REQ-030 Simultaneous events: o_level=2, last word of bundle 3 written in the same cycle as a take -> o_level stays 2; subsequent o_n sequence is bundles 2 then 3.
REQ-031 Underflow: i_take with o_level=0 -> o_n=0, o_level=0, no state change; o_err=1 and sticky with the macro, o_err=0 without it.
REQ-032 Reset mid-fill: rst_i pulsed after one word 0xAAAAAAAA -> all outputs at reset values; next words 0x1, 0x2 give o_n=0x0000000200000001.
REQ-033 Wrap-around: stream 10 bundles with random take pattern -> output sequence equals input sequence, with no loss and no duplicates.
